// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                    |
// | Purpose  : Shares one single-port data memory between the CPU MEM stage    |
// |            and a DMA port. CPU has default priority. DMA gets burst        |
// |            locking and starvation override.                                |
// | Option   : DMEM_ARB_STATS_EN adds stall and DMA-beat statistics counters.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int AW            = 5,
  parameter int DMA_BURST_MAX = 8,
  parameter int STARVE_LIM    = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
`ifdef DMEM_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] stall_cnt,
  output logic [15:0] dma_beat_cnt,
`endif
  input  logic [31:0] mem_rdata
);

  localparam int                  c_BEAT_W    = (DMA_BURST_MAX > 1) ? $clog2(DMA_BURST_MAX) : 1;
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(DMA_BURST_MAX - 1);
  localparam logic [2:0]          c_STARVE    = 3'(STARVE_LIM);

  // The wait counter is 3 bits wide and the word index must fit a 32-bit address.
  if ((AW < 1) || (AW > 30) || (STARVE_LIM < 1) || (STARVE_LIM > 7) || (DMA_BURST_MAX < 1))
  begin : g_param_err
    $error("dmem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_BEAT_W-1:0] r_beat_cnt;
  logic [2:0]          r_wait_cnt;
  logic                r_just_rel;
  logic [31:0]         r_dma_rdata;
  logic                r_dma_rvalid;

  logic w_cpu_grant;
  logic w_dma_grant;
  logic w_starved;
  logic w_last_beat;

  // Starvation override is suppressed for one cycle after a lock ends so the CPU gets a slot.
  assign w_starved   = (r_wait_cnt == c_STARVE) && !r_just_rel;
  assign w_last_beat = dma_last || (r_beat_cnt == c_BEAT_LAST);

  always_comb begin
    w_cpu_grant = 1'b0;
    w_dma_grant = 1'b0;
    if ((r_state == ST_DMA) && dma_req) begin
      w_dma_grant = 1'b1;
    end else if (w_starved && dma_req) begin
      w_dma_grant = 1'b1;
    end else if (cpu_req) begin
      w_cpu_grant = 1'b1;
    end else if (dma_req) begin
      w_dma_grant = 1'b1;
    end
  end

  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 1'b0;
    if (w_cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we && clr_n;
    end else if (w_dma_grant) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we && clr_n;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req && !w_cpu_grant;
  assign dma_gnt    = w_dma_grant;
  assign dma_rdata  = r_dma_rdata;
  assign dma_rvalid = r_dma_rvalid;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_just_rel <= 1'b0;
    end else begin
      r_just_rel <= 1'b0;
      if (w_dma_grant) begin
        if (w_last_beat) begin
          r_state    <= ST_IDLE;
          r_beat_cnt <= '0;
          r_just_rel <= 1'b1;
        end else begin
          r_state    <= ST_DMA;
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end else begin
        // Any cycle without a DMA grant ends a lock that may have been in progress.
        r_just_rel <= (r_state == ST_DMA);
        r_beat_cnt <= '0;
        r_state    <= w_cpu_grant ? ST_CPU : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wait_cnt <= 3'd0;
    end else if (!dma_req || w_dma_grant) begin
      r_wait_cnt <= 3'd0;
    end else if (r_wait_cnt < c_STARVE) begin
      r_wait_cnt <= r_wait_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_dma_rdata  <= 32'h0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_dma_rvalid <= w_dma_grant && !dma_we;
      if (w_dma_grant && !dma_we) begin
        r_dma_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_dma_beat_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_stall_cnt    <= 16'h0;
      r_dma_beat_cnt <= 16'h0;
    end else if (stats_clr) begin
      r_stall_cnt    <= 16'h0;
      r_dma_beat_cnt <= 16'h0;
    end else begin
      if (cpu_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'h1;
      end
      if (w_dma_grant && (r_dma_beat_cnt != 16'hFFFF)) begin
        r_dma_beat_cnt <= r_dma_beat_cnt + 16'h1;
      end
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign dma_beat_cnt = r_dma_beat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                                 |
// | Purpose  : Self-checking bench for dmem_arbiter with a behavioural memory. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] stall_cnt, dma_beat_cnt;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  logic        mem_init;
  logic [31:0] exp_q [$];
  logic [31:0] exp_d;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .clr_n(clr_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
`ifdef DMEM_ARB_STATS_EN
    .stats_clr(stats_clr), .stall_cnt(stall_cnt), .dma_beat_cnt(dma_beat_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_addr[6:2]] <= mem_wdata;
    end
  end

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0; dma_last = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b want 0", dma_rvalid); end
    n_checks++; if (dma_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", dma_rdata); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", cpu_stall); end
    n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0b want 0", dma_gnt); end
    n_checks++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin n_fail++; $display("FAIL reset_mem_bus: got we=%0b a=%h d=%h want all 0", mem_we, mem_addr, mem_wdata); end
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hBAD0BAD0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_forced: got %0b want 0", mem_we); end
    @(posedge clk);
    #1;
    n_checks++; if (mem[8] !== ref_mem[8]) begin n_fail++; $display("FAIL reset_no_write: got %h want %h", mem[8], ref_mem[8]); end
    idle_inputs();
    @(negedge clk) clr_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_store_load();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL store_stall: got %0b want 0", cpu_stall); end
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL store_we: got %0b want 1", mem_we); end
    n_checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_bus: got a=%h d=%h want a=00000010 d=deadbeef", mem_addr, mem_wdata); end
    ref_mem[4] = 32'hDEADBEEF;
    next_cycle();
    cpu_we = 1'b0;
    exp_q.push_back(ref_mem[4]);
    @(negedge clk);
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL load_stall: got %0b want 0", cpu_stall); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL load_we: got %0b want 0", mem_we); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    n_checks++; if (cpu_rdata !== exp_d) begin n_fail++; $display("FAIL load_rdata: got %h want %h", cpu_rdata, exp_d); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_starvation();
    bit exp_g;
    clr_n = 1'b0;
    next_cycle();
    clr_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40;
    for (int c = 1; c <= 13; c++) begin
      dma_wdata = 32'h5A5A0000 + c;
      exp_g = (c >= 5) && (c <= 12);
      @(negedge clk);
      n_checks++; if (dma_gnt !== exp_g) begin n_fail++; $display("FAIL starve_gnt c%0d: got %0b want %0b", c, dma_gnt, exp_g); end
      n_checks++; if (cpu_stall !== exp_g) begin n_fail++; $display("FAIL starve_stall c%0d: got %0b want %0b", c, cpu_stall, exp_g); end
      if (exp_g) ref_mem[16] = dma_wdata;
      else begin
        exp_q.push_back(ref_mem[4]);
        exp_d = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_d) begin n_fail++; $display("FAIL starve_rdata c%0d: got %h want %h", c, cpu_rdata, exp_d); end
      end
      next_cycle();
    end
    settle();
  endtask

  task automatic test_dma_burst();
    int  b;
    bit  exp_g;
    b = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (b < 3) begin
        dma_addr = 32'(b * 4); dma_wdata = 32'hA0000000 + 32'(b); dma_last = (b == 2);
      end else begin
        dma_req = 1'b0; dma_last = 1'b0;
      end
      exp_g = (c >= 5) && (c <= 7);
      @(negedge clk);
      n_checks++; if (dma_gnt !== exp_g) begin n_fail++; $display("FAIL burst_gnt c%0d: got %0b want %0b", c, dma_gnt, exp_g); end
      n_checks++; if (cpu_stall !== exp_g) begin n_fail++; $display("FAIL burst_stall c%0d: got %0b want %0b", c, cpu_stall, exp_g); end
      if (dma_gnt === 1'b1 && b < 3) begin
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'(b * 4)) begin n_fail++; $display("FAIL burst_bus b%0d: got we=%0b a=%h want we=1 a=%h", b, mem_we, mem_addr, 32'(b * 4)); end
        ref_mem[b] = 32'hA0000000 + 32'(b);
        b++;
      end
      next_cycle();
    end
    settle();
  endtask

  task automatic test_dma_long();
    bit exp_g, exp_s;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h60;
    for (int c = 1; c <= 17; c++) begin
      cpu_req   = (c >= 12);
      dma_wdata = 32'hC0DE0000 + c;
      exp_g = (c <= 16);
      exp_s = (c >= 12) && (c <= 16);
      @(negedge clk);
      n_checks++; if (dma_gnt !== exp_g) begin n_fail++; $display("FAIL long_gnt c%0d: got %0b want %0b", c, dma_gnt, exp_g); end
      n_checks++; if (cpu_stall !== exp_s) begin n_fail++; $display("FAIL long_stall c%0d: got %0b want %0b", c, cpu_stall, exp_s); end
      if (exp_g) ref_mem[24] = dma_wdata;
      next_cycle();
    end
    settle();
  endtask

  task automatic test_dma_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1C; cpu_wdata = 32'h12345678;
    @(negedge clk);
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rd_prep_stall: got %0b want 0", cpu_stall); end
    ref_mem[7] = 32'h12345678;
    next_cycle();
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1C;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt0: got %0b want 1", dma_gnt); end
    n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_early: got %0b want 0", dma_rvalid); end
    exp_q.push_back(ref_mem[7]);
    next_cycle();
    dma_addr = 32'h08; dma_last = 1'b1;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt1: got %0b want 1", dma_gnt); end
    n_checks++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid0: got %0b want 1", dma_rvalid); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    n_checks++; if (dma_rdata !== exp_d) begin n_fail++; $display("FAIL rd_data0: got %h want %h", dma_rdata, exp_d); end
    exp_q.push_back(ref_mem[2]);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid1: got %0b want 1", dma_rvalid); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    n_checks++; if (dma_rdata !== exp_d) begin n_fail++; $display("FAIL rd_data1: got %h want %h", dma_rdata, exp_d); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_late: got %0b want 0", dma_rvalid); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rd_queue_left: got %0d want 0", exp_q.size()); end
    settle();
  endtask

  task automatic test_reset_mid_burst();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h11111111;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt0: got %0b want 1", dma_gnt); end
    ref_mem[12] = 32'h11111111;
    next_cycle();
    dma_we = 1'b0; dma_addr = 32'h1C;
    exp_q.push_back(ref_mem[7]);
    next_cycle();
    dma_we = 1'b1; dma_addr = 32'h34; dma_wdata = 32'h22222222;
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_rvalid: got %0b want 1", dma_rvalid); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    n_checks++; if (dma_rdata !== exp_d) begin n_fail++; $display("FAIL mid_rdata: got %h want %h", dma_rdata, exp_d); end
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_we_pre: got %0b want 1", mem_we); end
    clr_n = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_we_rst: got %0b want 0", mem_we); end
    n_checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rvalid_rst: got v=%0b d=%h want v=0 d=0", dma_rvalid, dma_rdata); end
    @(posedge clk);
    #1;
    n_checks++; if (mem[13] !== ref_mem[13]) begin n_fail++; $display("FAIL mid_no_write: got %h want %h", mem[13], ref_mem[13]); end
    @(negedge clk);
    clr_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h14; cpu_wdata = 32'hCAFEF00D;
    #1;
    n_checks++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_cpu_after: got stall=%0b gnt=%0b want 0 0", cpu_stall, dma_gnt); end
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h14) begin n_fail++; $display("FAIL mid_cpu_bus: got we=%0b a=%h want we=1 a=00000014", mem_we, mem_addr); end
    ref_mem[5] = 32'hCAFEF00D;
    next_cycle();
    settle();
  endtask

  task automatic test_mem_contents();
    for (int i = 0; i < 32; i++) begin
      n_checks++; if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL mem_word%0d: got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_init = 1'b1;
    clr_n    = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    idle_inputs();
    test_reset();
    test_cpu_store_load();
    test_starvation();
    test_dma_burst();
    test_dma_long();
    test_dma_read();
    test_reset_mid_burst();
    test_mem_contents();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32-word data memory between the pipeline MEM stage (CPU port) and a DMA/test-loader port.
- One memory access per cycle.
- CPU has default priority; DMA gets burst locking and starvation protection.
- Sits between the MEM stage / DMA engine and the data memory. Memory reads are combinational; writes commit on posedge clk.

Parameters:
- AW, 5: word-address bits; memory word index = addr[AW+1:2].
- DMA_BURST_MAX, 8: max DMA beats per lock before forced release.
- STARVE_LIM, 4: DMA wait cycles before DMA overrides CPU (range 1..7).

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- cpu_req  in  1  MEM stage access request
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address (ALU result)
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, combinational, valid when cpu_req & ~cpu_stall
- cpu_stall  out  1  hold pipeline; request not served this cycle
- dma_req  in  1  DMA beat request
- dma_we  in  1  1=write, 0=read
- dma_addr  in  32  byte address
- dma_wdata  in  32  write data
- dma_last  in  1  final beat of burst
- dma_gnt  out  1  beat accepted this cycle
- dma_rdata  out  32  registered read data
- dma_rvalid  out  1  dma_rdata valid; pulses 1 cycle after a granted read
- mem_addr  out  32  to memory (ALU-result input)
- mem_wdata  out  32  to memory
- mem_we  out  1  to memory write enable
- mem_rdata  in  32  from memory Dout

Behaviour:
- States (registered): IDLE, CPU, DMA. Grant is decided combinationally from state, requests and counters.
- Grant priority each cycle:
  1. state==DMA & dma_req → DMA.
  2. wait_cnt==STARVE_LIM & dma_req → DMA.
  3. cpu_req → CPU.
  4. dma_req → DMA.
  5. Otherwise none.
- Fairness: on the cycle after a DMA lock releases, cpu_req has priority even if wait_cnt==STARVE_LIM.
- CPU grant:
  - mem_* = cpu_*; cpu_rdata = mem_rdata (zero latency); cpu_stall=0.
  - cpu_stall = cpu_req & ~cpu_grant.
- DMA grant:
  - mem_* = dma_*; dma_gnt=1.
  - On a read, dma_rdata <= mem_rdata and dma_rvalid <= 1 at the next edge.
- No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- mem_we is only ever asserted for the granted port's write.
- wait_cnt (3b):
  - +1 (saturating at STARVE_LIM) each cycle dma_req & ~dma_gnt.
  - Cleared on dma_gnt or when ~dma_req.
- beat_cnt:
  - Counts granted beats within a DMA lock.
  - Lock is entered on the first DMA grant; state goes to DMA.
  - Lock releases (state→IDLE, beat_cnt→0) after a granted beat with dma_last, or beat_cnt==DMA_BURST_MAX-1, or on any cycle with ~dma_req while in DMA.
- State goes to CPU after a CPU grant, and to IDLE when nothing is granted.
- Simultaneous cpu_req/dma_req in IDLE with wait_cnt<STARVE_LIM: CPU wins; DMA waits.
- Back-to-back CPU requests with DMA waiting: CPU is served until wait_cnt reaches STARVE_LIM.
- Reset (async, clr_n=0): state=IDLE, wait_cnt=0, beat_cnt=0, dma_rvalid=0, dma_rdata=0.
  - Combinational outputs follow from IDLE with inputs.
  - Mid-burst reset abandons the burst; no write occurs while clr_n=0 (mem_we forced 0).

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds input stats_clr (1b) and outputs stall_cnt (16b) and dma_beat_cnt (16b).
  - stall_cnt: saturating count of cycles with cpu_stall=1.
  - dma_beat_cnt: saturating count of dma_gnt cycles.
  - Both clear on reset or stats_clr. stats_clr has priority over increment in the same cycle.
- When undefined: those ports and counters are absent; the arbiter behaviour is identical.

Test Plan:
- CPU store addr 0x0000_0010 data 0xDEADBEEF, then load same addr → no stall; mem_we=1 for 1 cycle; load cpu_rdata=0xDEADBEEF in same cycle.
- cpu_req and dma_req both held from reset, STARVE_LIM=4:
  - CPU granted 4 cycles with cpu_stall=0.
  - DMA granted cycle 5 and cpu_stall=1 that cycle.
  - Next cycle: if DMA still requesting, lock holds until dma_last/drop (cpu_stall stays 1); after release CPU is granted.
- DMA 3-beat write burst to 0x00,0x04,0x08 with dma_last on beat 3 while CPU requests:
  - dma_gnt 3 consecutive cycles; cpu_stall=1 for those 3 cycles.
  - CPU granted on 4th cycle.
- DMA continuous request >8 beats, CPU idle → lock releases after beat 8; if cpu_req asserted, CPU gets next slot, else DMA relocks.
- DMA read of 0x1C holding 0x12345678 → dma_rvalid=1 one cycle after dma_gnt with dma_rdata=0x12345678; dma_rvalid=0 otherwise.
- clr_n low mid-DMA-burst → state IDLE, dma_rvalid=0, mem_we=0 immediately; after release, CPU request granted with no stall.
